reaction_score_keeper: RTL and testbench
========================================

Name: reaction_score_keeper

Overview:
- Downstream consumer of the 12-bit reaction-time counter. Captures each finished trial's millisecond count and tracks last, best and 4-trial running average results.
- Presents one selected 12-bit value to the binary-to-BCD / 7-segment display path.
- Sits between the reaction counter/FSM and the BCD converter.
- Supplies the best-time indication for the LED bank.

Parameters:
- WIDTH, 12, bit width of the time value (ms).
- AVG_LOG2, 2, log2 of the averaging window depth (4 trials).
- CNT_W, 8, width of the trial and false-start counters.

Ports:
- Board_clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- time_in  input  WIDTH  reaction time in ms from the reaction counter. Valid only when time_valid=1.
- time_valid  input  1  single-cycle pulse: trial finished, time_in is final.
- false_start  input  1  single-cycle pulse: player pressed before the stimulus.
- clear_best  input  1  level; best register returns to its reset value.
- view_sel  input  2  display select: 00 last, 01 best, 10 average, 11 trial count (zero-extended).
- disp_out  output  WIDTH  registered selected value, to the BCD converter.
- new_best  output  1  registered single-cycle pulse: the accepted trial beat best.
- avg_ready  output  1  high once 2^AVG_LOG2 valid trials are in the window.
- trial_count  output  CNT_W  number of valid trials accepted; saturates.
- false_count  output  CNT_W  number of false starts; saturates.

Behaviour:
- Reset (synchronous, dominates all other inputs in its cycle):
  - last=0, best=all-ones (4095), window entries=0, sum=0, fill=0.
  - trial_count=0, false_count=0, disp_out=0, new_best=0, avg_ready=0.
- Accepted trial (time_valid=1, false_start=0):
  - last<=time_in; trial_count increments, saturating at 2^CNT_W-1.
  - If time_in < best (strict), best<=time_in and new_best=1 in the next cycle. An equal time does not update best and gives no pulse.
  - Window: 4-entry circular buffer, write pointer wraps 3->0.
  - sum<=sum - oldest + time_in. sum is WIDTH+AVG_LOG2 bits (14) and never overflows.
  - fill increments up to 4. avg_ready=1 from the cycle after the 4th accepted trial and stays high until Reset.
  - avg = sum >> AVG_LOG2 (truncating). avg reads 0 while avg_ready=0.
- False start (false_start=1): false_count increments (saturating); last<=all-ones. Best, window, sum and trial_count are unchanged.
- time_valid and false_start in the same cycle: the false start wins and time_in is discarded.
- clear_best=1: best<=all-ones. If clear_best and an accepted trial fall in the same cycle, best<=time_in and new_best=1 (a cleared best is beaten by any value < 4095).
- Time saturation: time_in=4095 is a legal value and is stored. It never produces new_best against a reset best.
- disp_out:
  - Registered mux of {last, best, avg, zero-extended trial_count}, selected by view_sel.
  - Latency is 1 cycle from a view_sel change, and 1 cycle from the register update. A trial at cycle N reaches disp_out at N+2.
- new_best is high for exactly one cycle per qualifying trial.
- No internal FSM beyond the fill counter; all storage in registers (no RAM inference required).

Test Plan:
- Reset, view_sel=01 -> disp_out=4095 two cycles later; trial_count=0, avg_ready=0, new_best=0.
- Trials 250, 300, 200 ms -> new_best pulses after 250 and 200 only; best=200, last=200, trial_count=3, avg_ready=0, view_sel=10 shows 0.
- 4th trial 350 -> avg_ready=1, avg=(250+300+200+350)>>2=275. A 5th trial of 100 -> avg=(300+200+350+100)>>2=237; new_best pulses.
- false_start pulse (with simultaneous time_valid, time_in=50) -> false_count=1, last=4095, best unchanged at 100, trial_count unchanged, window/avg unchanged.
- Equal-time trial 100 -> no new_best. clear_best together with time_valid, time_in=180 -> best=180, new_best=1.
- Drive 260 valid trials -> trial_count saturates at 255. Reset asserted mid-sequence clears every output on the next edge regardless of a concurrent time_valid.

Source files
------------

// File: rtl/reaction_score_keeper.sv
// reaction_score_keeper: captures finished trial times and tracks last, best and running-average results for display.
module reaction_score_keeper #(
  parameter int WIDTH    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int CNT_W    = 8
) (
  input  logic             Board_clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] time_in,
  input  logic             time_valid,
  input  logic             false_start,
  input  logic             clear_best,
  input  logic [1:0]       view_sel,
  output logic [WIDTH-1:0] disp_out,
  output logic             new_best,
  output logic             avg_ready,
  output logic [CNT_W-1:0] trial_count,
  output logic [CNT_W-1:0] false_count
);
  localparam int DEPTH = 2 ** AVG_LOG2;
  localparam int SW    = WIDTH + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0]    last_q, last_d, best_q, best_d, best_base, oldest, avg, disp_q, disp_d;
  logic [WIDTH-1:0]    win_q [DEPTH];
  logic [SW-1:0]       sum_q, sum_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [AVG_LOG2-1:0] wptr_q;
  logic [CNT_W-1:0]    trial_q, trial_d, false_q, false_d;
  logic                new_best_q, acc, hit;

  always_comb begin
    acc       = time_valid & ~false_start;
    best_base = clear_best ? MAX : best_q;
    hit       = acc && (time_in < best_base);
    best_d    = hit ? time_in : best_base;
    last_d    = false_start ? MAX : (acc ? time_in : last_q);
    oldest    = win_q[wptr_q];
    // Unfilled window slots hold zero, so subtracting the oldest entry is always safe.
    sum_d     = acc ? sum_q - SW'(oldest) + SW'(time_in) : sum_q;
    fill_d    = (acc && fill_q != FW'(DEPTH)) ? fill_q + 1'b1 : fill_q;
    trial_d   = (acc && trial_q != '1) ? trial_q + 1'b1 : trial_q;
    false_d   = (false_start && false_q != '1) ? false_q + 1'b1 : false_q;
    avg       = avg_ready ? WIDTH'(sum_q >> AVG_LOG2) : '0;
    disp_d    = view_sel[1] ? (view_sel[0] ? WIDTH'(trial_q) : avg)
                            : (view_sel[0] ? best_q : last_q);
  end

  always_ff @(posedge Board_clk) begin
    if (Reset) begin
      last_q     <= '0;
      best_q     <= MAX;
      sum_q      <= '0;
      fill_q     <= '0;
      wptr_q     <= '0;
      trial_q    <= '0;
      false_q    <= '0;
      disp_q     <= '0;
      new_best_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      last_q     <= last_d;
      best_q     <= best_d;
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      trial_q    <= trial_d;
      false_q    <= false_d;
      disp_q     <= disp_d;
      new_best_q <= hit;
      if (acc) begin
        win_q[wptr_q] <= time_in;
        wptr_q        <= wptr_q + 1'b1;
      end
    end
  end

  assign disp_out    = disp_q;
  assign new_best    = new_best_q;
  assign avg_ready   = (fill_q == FW'(DEPTH));
  assign trial_count = trial_q;
  assign false_count = false_q;
endmodule

// File: tb/tb_reaction_score_keeper.sv
// tb_reaction_score_keeper: directed trials with a queued scoreboard checked by a negedge monitor.
module tb_reaction_score_keeper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] time_in = '0;
  logic        time_valid = 1'b0, false_start = 1'b0, clear_best = 1'b0;
  logic [1:0]  view_sel = 2'b01;
  logic [11:0] disp_out;
  logic        new_best, avg_ready;
  logic [7:0]  trial_count, false_count;

  typedef struct {string name; int sel; int unsigned exp;} chk_t;
  chk_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  reaction_score_keeper dut (
    .Board_clk(clk), .Reset(rst), .time_in(time_in), .time_valid(time_valid),
    .false_start(false_start), .clear_best(clear_best), .view_sel(view_sel),
    .disp_out(disp_out), .new_best(new_best), .avg_ready(avg_ready),
    .trial_count(trial_count), .false_count(false_count)
  );

  function automatic int unsigned probe(input int s);
    case (s)
      0: return int'(disp_out);
      1: return int'(new_best);
      2: return int'(avg_ready);
      3: return int'(trial_count);
      default: return int'(false_count);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      int unsigned a;
      c = sb.pop_front();
      a = probe(c.sel);
      checks++;
      if (a !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", c.name, a, c.exp, $time);
      end
    end
  end

  task automatic chk(input string n, input int s, input int unsigned e);
    sb.push_back('{n, s, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trial(input int t);
    time_valid = 1'b1;
    time_in = 12'(t);
    tick();
    time_valid = 1'b0;
  endtask

  task automatic view(input logic [1:0] v);
    view_sel = v;
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_disp", 0, 0);
    tick();
    chk("reset_best_disp", 0, 4095);
    chk("reset_trials", 3, 0);
    chk("reset_avg_ready", 2, 0);
    chk("reset_new_best", 1, 0);
    chk("reset_false", 4, 0);
    trial(250);
    chk("nb_250", 1, 1);
    chk("tc_1", 3, 1);
    trial(300);
    chk("nb_300", 1, 0);
    trial(200);
    chk("nb_200", 1, 1);
    chk("tc_3", 3, 3);
    chk("avg_ready_3", 2, 0);
    tick();
    chk("nb_pulse_end", 1, 0);
    chk("best_200", 0, 200);
    view(2'b00);
    chk("last_200", 0, 200);
    view(2'b10);
    chk("avg_not_ready", 0, 0);
    trial(350);
    chk("nb_350", 1, 0);
    chk("avg_ready_4", 2, 1);
    chk("tc_4", 3, 4);
    tick();
    chk("avg_275", 0, 275);
    trial(100);
    chk("nb_100", 1, 1);
    tick();
    chk("avg_237", 0, 237);
    view(2'b01);
    chk("best_100", 0, 100);
    time_valid = 1'b1;
    false_start = 1'b1;
    time_in = 12'd50;
    tick();
    time_valid = 1'b0;
    false_start = 1'b0;
    chk("fs_count", 4, 1);
    chk("fs_tc", 3, 5);
    chk("fs_nb", 1, 0);
    view(2'b00);
    chk("fs_last", 0, 4095);
    view(2'b01);
    chk("fs_best", 0, 100);
    view(2'b10);
    chk("fs_avg", 0, 237);
    trial(100);
    chk("nb_equal", 1, 0);
    chk("tc_6", 3, 6);
    tick();
    chk("avg_187", 0, 187);
    view_sel = 2'b01;
    clear_best = 1'b1;
    trial(180);
    clear_best = 1'b0;
    chk("nb_clear_trial", 1, 1);
    tick();
    chk("best_180", 0, 180);
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    tick();
    chk("best_cleared", 0, 4095);
    trial(4095);
    chk("nb_4095", 1, 0);
    chk("tc_8", 3, 8);
    view(2'b00);
    chk("last_4095", 0, 4095);
    view(2'b11);
    chk("disp_tc_8", 0, 8);
    for (int i = 0; i < 260; i++) trial(500);
    chk("tc_sat", 3, 255);
    tick();
    chk("disp_tc_sat", 0, 255);
    rst = 1'b1;
    time_valid = 1'b1;
    false_start = 1'b1;
    time_in = 12'd10;
    tick();
    time_valid = 1'b0;
    false_start = 1'b0;
    chk("rst_disp", 0, 0);
    chk("rst_tc", 3, 0);
    chk("rst_fc", 4, 0);
    chk("rst_avg_ready", 2, 0);
    chk("rst_nb", 1, 0);
    rst = 1'b0;
    view(2'b01);
    chk("rst_best", 0, 4095);
    tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
